// File: rtl/instr_decoder.sv
// Instruction decoder: buffers raw words in a small FIFO and emits decoded,
// legality-checked instructions under a start/halt run control.
package instr_decoder_pkg;

    typedef struct packed {
        logic [2:0]  mac_op;
        logic [7:0]  v_dim;
        logic [7:0]  u_dim;
        logic [7:0]  iter_dim;
        logic [11:0] rd_addr;
        logic [11:0] wr_addr;
        logic [6:0]  v_dim1;
        logic [6:0]  u_dim1;
        logic [6:0]  iter_dim1;
    } decoded_instr_t;

endpackage

module instr_decoder
    import instr_decoder_pkg::*;
#(
    parameter int INSTR_SIZE = 52,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [INSTR_SIZE-1:0] instr_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    output decoded_instr_t        dec_o,
    output logic                  dec_valid_o,
    input  logic                  dec_ready_i,
    output logic                  err_o,
    output logic [7:0]            err_cnt_o,
    output logic                  busy_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t state_q, state_d;

    logic [INSTR_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic [INSTR_SIZE-1:0] head;

    logic push, pop;
    logic is_end, is_nop, illegal;
    logic [7:0] v_dim, u_dim, iter_dim;
    decoded_instr_t dec_d;

    assign instr_ready_o = (count < FULL);
    assign push = instr_valid_i && instr_ready_o;
    assign pop  = (state_q == RUN) && (count != '0)
                && (!dec_valid_o || dec_ready_i);
    assign busy_o = (state_q == RUN) || (count != '0) || dec_valid_o;

    assign head     = mem[rd_ptr];
    assign is_end   = head[51];
    assign is_nop   = (head[50:48] == 3'd0);
    assign v_dim    = head[47:40];
    assign u_dim    = head[39:32];
    assign iter_dim = head[31:24];
    assign illegal  = (v_dim == 8'd0) || (v_dim > 8'd128)
                   || (u_dim == 8'd0) || (u_dim > 8'd128)
                   || (iter_dim == 8'd0) || (iter_dim > 8'd128);

    // low 7 bits of (dim - 1): 128 maps to 127, 1 maps to 0
    always_comb begin
        dec_d           = '0;
        dec_d.mac_op    = head[50:48];
        dec_d.v_dim     = v_dim;
        dec_d.u_dim     = u_dim;
        dec_d.iter_dim  = iter_dim;
        dec_d.rd_addr   = head[23:12];
        dec_d.wr_addr   = head[11:0];
        dec_d.v_dim1    = v_dim[6:0] - 7'd1;
        dec_d.u_dim1    = u_dim[6:0] - 7'd1;
        dec_d.iter_dim1 = iter_dim[6:0] - 7'd1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (pop && is_end) state_d = HALTED;
            HALTED:  if (start_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= instr_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_o       <= '0;
            dec_valid_o <= 1'b0;
            err_o       <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            err_o <= pop && !is_nop && illegal;
            if (pop && !is_nop && illegal && err_cnt_o != 8'hff)
                err_cnt_o <= err_cnt_o + 8'd1;
            if (pop && !is_nop && !illegal) begin
                dec_o       <= dec_d;
                dec_valid_o <= 1'b1;
            end else if (dec_ready_i) begin
                dec_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_decoder.sv
// Bench for instr_decoder: directed scenarios plus random traffic
// scored against a transaction-level reference model.
module tb_instr_decoder;
    import instr_decoder_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0;
    logic [51:0]    instr_i = '0;
    logic           instr_valid_i = 1'b0;
    logic           instr_ready_o;
    decoded_instr_t dec_o;
    logic           dec_valid_o;
    logic           dec_ready_i = 1'b0;
    logic           err_o;
    logic [7:0]     err_cnt_o;
    logic           busy_o;

    instr_decoder #(.INSTR_SIZE(52), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o), .dec_o(dec_o),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .err_o(err_o), .err_cnt_o(err_cnt_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int err_pulses = 0;
    int n_ill = 0;
    bit rnd_on = 1'b0;
    decoded_instr_t seen[$];
    decoded_instr_t exp_q[$];

    function automatic logic [51:0] mk(logic e, logic [2:0] op,
            logic [7:0] v, logic [7:0] u, logic [7:0] it,
            logic [11:0] rd, logic [11:0] wr);
        return {e, op, v, u, it, rd, wr};
    endfunction

    function automatic int fld(logic [51:0] w, int lsb, int width);
        return int'((w >> lsb) % (64'd1 << width));
    endfunction

    function automatic bit legal(logic [51:0] w);
        int v, u, it;
        v = fld(w, 40, 8);
        u = fld(w, 32, 8);
        it = fld(w, 24, 8);
        return v >= 1 && v <= 128 && u >= 1 && u <= 128
            && it >= 1 && it <= 128;
    endfunction

    function automatic decoded_instr_t ref_dec(logic [51:0] w);
        decoded_instr_t d;
        d.mac_op    = 3'(fld(w, 48, 3));
        d.v_dim     = 8'(fld(w, 40, 8));
        d.u_dim     = 8'(fld(w, 32, 8));
        d.iter_dim  = 8'(fld(w, 24, 8));
        d.rd_addr   = 12'(fld(w, 12, 12));
        d.wr_addr   = 12'(fld(w, 0, 12));
        d.v_dim1    = 7'(fld(w, 40, 8) - 1);
        d.u_dim1    = 7'(fld(w, 32, 8) - 1);
        d.iter_dim1 = 7'(fld(w, 24, 8) - 1);
        return d;
    endfunction

    function automatic logic [7:0] rand_dim();
        int r;
        r = int'($urandom % 16);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'(129 + $urandom % 127);
        return 8'(1 + $urandom % 128);
    endfunction

    function automatic logic [51:0] rand_word();
        return mk(($urandom % 16) == 0, 3'($urandom % 8), rand_dim(),
                  rand_dim(), rand_dim(), 12'($urandom), 12'($urandom));
    endfunction

    always @(negedge clk) begin
        if (rst_n && dec_valid_o && dec_ready_i) seen.push_back(dec_o);
        if (err_o) err_pulses++;
        if (rnd_on && rst_n && instr_valid_i && instr_ready_o
            && fld(instr_i, 48, 3) != 0) begin
            if (legal(instr_i)) exp_q.push_back(ref_dec(instr_i));
            else n_ill++;
        end
    end

    task automatic check(string tag, logic [71:0] obs, logic [71:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_i = 1'b0;
        instr_valid_i = 1'b0;
        dec_ready_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic push(logic [51:0] w);
        int t = 0;
        instr_i = w;
        instr_valid_i = 1'b1;
        while (!instr_ready_o && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) check("push_timeout", instr_ready_o, 1);
        tick();
        instr_valid_i = 1'b0;
    endtask

    task automatic wait_valid(int lim);
        int t = 0;
        while (!dec_valid_o && t < lim) begin
            tick();
            t++;
        end
        check("wait_valid", dec_valid_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [51:0] w [5];
        logic [51:0] wa, wb, wx;
        decoded_instr_t e27;
        int lim;

        do_reset();
        check("rst_valid", dec_valid_o, 0);
        check("rst_dec", dec_o, 0);
        check("rst_err", err_o, 0);
        check("rst_errcnt", err_cnt_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", instr_ready_o, 1);

        // single legal word, exact latency
        pulse_start();
        dec_ready_i = 1'b1;
        instr_i = mk(1'b0, 3'd1, 8'd32, 8'd16, 8'd128, 12'h010, 12'h200);
        instr_valid_i = 1'b1;
        check("lat_ready", instr_ready_o, 1);
        tick();
        instr_valid_i = 1'b0;
        check("lat_n1", dec_valid_o, 0);
        tick();
        check("lat_n2", dec_valid_o, 1);
        e27.mac_op = 3'd1;
        e27.v_dim = 8'd32;
        e27.u_dim = 8'd16;
        e27.iter_dim = 8'd128;
        e27.rd_addr = 12'h010;
        e27.wr_addr = 12'h200;
        e27.v_dim1 = 7'd31;
        e27.u_dim1 = 7'd15;
        e27.iter_dim1 = 7'd127;
        check("lat_dec", dec_o, e27);
        tick();
        check("lat_consumed", dec_valid_o, 0);

        // fill in IDLE, then drain one per cycle
        do_reset();
        for (int i = 0; i < 5; i++)
            w[i] = mk(1'b0, 3'(1 + i % 7), 8'(10 + i), 8'(20 + i),
                      8'(30 + i), 12'(i), 12'(100 + i));
        for (int i = 0; i < 5; i++) begin
            instr_i = w[i];
            instr_valid_i = 1'b1;
            check("fill_ready", instr_ready_o, i < 4);
            tick();
        end
        instr_valid_i = 1'b0;
        check("full_ready", instr_ready_o, 0);
        dec_ready_i = 1'b1;
        pulse_start();
        wait_valid(5);
        for (int k = 0; k < 4; k++) begin
            check("order_valid", dec_valid_o, 1);
            check("order_data", dec_o, ref_dec(w[k]));
            tick();
        end
        check("drain_done", dec_valid_o, 0);

        // illegal word between two legal ones
        seen.delete();
        err_pulses = 0;
        wa = mk(1'b0, 3'd2, 8'd5, 8'd6, 8'd7, 12'h111, 12'h222);
        wx = mk(1'b0, 3'd3, 8'd5, 8'd0, 8'd7, 12'h333, 12'h444);
        wb = mk(1'b0, 3'd4, 8'd1, 8'd128, 8'd64, 12'hfff, 12'h000);
        push(wa);
        push(wx);
        push(wb);
        repeat (6) tick();
        check("ill_outs", seen.size(), 2);
        if (seen.size() >= 2) begin
            check("ill_first", seen[0], ref_dec(wa));
            check("ill_second", seen[1], ref_dec(wb));
        end
        check("ill_pulses", err_pulses, 1);
        check("ill_cnt", err_cnt_o, 1);
        for (int i = 0; i < 300; i++)
            push(mk(1'b0, 3'(1 + i % 7), (i % 3 == 0) ? 8'd0 : 8'd9,
                    (i % 3 == 1) ? 8'd200 : 8'd9,
                    (i % 3 == 2) ? 8'd129 : 8'd9, 12'(i), 12'(i)));
        repeat (5) tick();
        check("sat_cnt", err_cnt_o, 255);
        check("sat_outs", seen.size(), 2);

        // END on the second of three words
        do_reset();
        dec_ready_i = 1'b1;
        pulse_start();
        seen.delete();
        w[0] = mk(1'b0, 3'd1, 8'd3, 8'd4, 8'd5, 12'h001, 12'h002);
        w[1] = mk(1'b1, 3'd5, 8'd6, 8'd7, 8'd8, 12'h003, 12'h004);
        w[2] = mk(1'b0, 3'd6, 8'd9, 8'd10, 8'd11, 12'h005, 12'h006);
        push(w[0]);
        push(w[1]);
        push(w[2]);
        repeat (6) tick();
        check("halt_outs", seen.size(), 2);
        check("halt_busy", busy_o, 1);
        check("halt_valid", dec_valid_o, 0);
        pulse_start();
        repeat (4) tick();
        check("resume_outs", seen.size(), 3);
        if (seen.size() >= 3) check("resume_data", seen[2], ref_dec(w[2]));

        // backpressure hold, then reset mid-hold
        do_reset();
        for (int i = 0; i < 5; i++)
            w[i] = mk(1'b0, 3'd7, 8'(40 + i), 8'(50 + i), 8'(60 + i),
                      12'(200 + i), 12'(300 + i));
        for (int i = 0; i < 4; i++) push(w[i]);
        pulse_start();
        wait_valid(5);
        push(w[4]);
        for (int k = 0; k < 5; k++) begin
            check("hold_data", dec_o, ref_dec(w[0]));
            check("hold_valid", dec_valid_o, 1);
            check("hold_nopop", instr_ready_o, 0);
            tick();
        end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_valid", dec_valid_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_dec", dec_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_ready", instr_ready_o, 1);
        check("arst_empty", busy_o, 0);

        // random traffic against the transaction model
        do_reset();
        seen.delete();
        exp_q.delete();
        n_ill = 0;
        err_pulses = 0;
        rnd_on = 1'b1;
        repeat (3000) begin
            instr_valid_i = ($urandom % 10) < 7;
            instr_i = rand_word();
            dec_ready_i = ($urandom % 10) < 7;
            start_i = ($urandom % 12) == 0;
            tick();
        end
        instr_valid_i = 1'b0;
        dec_ready_i = 1'b1;
        repeat (60) begin
            pulse_start();
            tick();
            tick();
        end
        rnd_on = 1'b0;
        check("rnd_count", seen.size(), exp_q.size());
        lim = (seen.size() < exp_q.size()) ? seen.size() : exp_q.size();
        for (int i = 0; i < lim; i++) check("rnd_data", seen[i], exp_q[i]);
        check("rnd_pulses", err_pulses, n_ill);
        check("rnd_errcnt", err_cnt_o, (n_ill > 255) ? 255 : n_ill);
        check("rnd_idle_out", dec_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 SHALL have parameter INSTR_SIZE, default 52, raw instruction width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of raw-instruction buffer entries (power of two, ≥2).
REQ-003 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have the port start_i, input, 1 bit: single-cycle pulse that enables decoding from IDLE or HALTED.
REQ-006 SHALL have the port instr_i, input, INSTR_SIZE bits: raw instruction word.
REQ-007 SHALL have the port instr_valid_i, input, 1 bit: instr_i is valid this cycle.
REQ-008 SHALL have the port instr_ready_o, output, 1 bit: the block accepts instr_i this cycle.
REQ-009 SHALL have the port dec_o, output, decoded_instr_t (72 bits): decoded instruction.
REQ-010 SHALL have the port dec_valid_o, output, 1 bit: dec_o is valid.
REQ-011 SHALL have the port dec_ready_i, input, 1 bit: the downstream controller consumes dec_o.
REQ-012 SHALL have the port err_o, output, 1 bit: one-cycle pulse when an illegal instruction is dropped.
REQ-013 SHALL have the port err_cnt_o, output, 8 bits: saturating count of dropped illegal instructions.
REQ-014 SHALL have the port busy_o, output, 1 bit: state is RUN, or the FIFO is non-empty, or dec_valid_o is high.

Function
REQ-015 Raw format SHALL be: [51] END, [50:48] MAC_op, [47:40] V_dim, [39:32] U_dim, [31:24] ITER_dim, [23:12] unified-buffer read start address, [11:0] unified-buffer write start address.
REQ-016 Decode SHALL copy MAC_op, V_dim, U_dim, ITER_dim and both addresses unchanged into dec_o, and set V_dim1/U_dim1/ITER_dim1 = (dim − 1)[6:0].
REQ-017 An instruction SHALL be illegal if any dim is 0 or >128; an illegal instruction is not emitted, err_o pulses in the cycle after its FIFO pop, and err_cnt_o increments and saturates at 255.
REQ-018 MAC_op = 0 (NOP) SHALL be popped and discarded without error and without output; its END bit is still honoured.
REQ-019 Accept handshake: a word SHALL be written to the FIFO iff instr_valid_i && instr_ready_o; instr_ready_o = (FIFO count < FIFO_DEPTH), a function of registered count only, so a simultaneous pop does not raise ready while full.
REQ-020 Output handshake: dec_o and dec_valid_o SHALL be registered and held stable while dec_valid_o && !dec_ready_i; transfer occurs on dec_valid_o && dec_ready_i.
REQ-021 States SHALL be IDLE, RUN and HALTED; the FIFO pops only in RUN, when it is non-empty and the output register is empty or being consumed in the same cycle.
REQ-022 Transitions: IDLE→RUN on start_i; RUN→HALTED in the cycle after popping a word with END=1 (legal, illegal or NOP); HALTED→RUN on start_i; start_i in RUN SHALL be ignored.
REQ-023 Latency: a word accepted in cycle N into an empty FIFO, in RUN, with the output register free, SHALL appear on dec_valid_o in cycle N+2; throughput SHALL be one instruction per cycle under continuous dec_ready_i.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop SHALL leave the count unchanged; accepting in IDLE/HALTED SHALL continue until full.
REQ-025 The FIFO SHALL never overflow or underflow; order SHALL be preserved.

Reset
REQ-026 On rst_n low, at any time including mid-transfer: state=IDLE, FIFO empty, dec_valid_o=0, dec_o=0, err_o=0, err_cnt_o=0, busy_o=0, instr_ready_o=1 one cycle after release; buffered words SHALL be discarded.

Verification
REQ-027 Legal word V=32,U=16,ITER=128,op=1, rd=0x010, wr=0x200 accepted at N after start_i → dec_valid_o at N+2, V_dim1=31, U_dim1=15, ITER_dim1=127, addresses unchanged.
REQ-028 Five words pushed in IDLE with dec_ready_i=0 → four accepted, instr_ready_o=0 on the fifth; after start_i with dec_ready_i=1, four outputs in push order, one per cycle.
REQ-029 Word with U_dim=0 between two legal words → only the two legal outputs, err_o one pulse, err_cnt_o=1; 300 illegal words → err_cnt_o=255.
REQ-030 Second of three words has END=1 → two outputs, state HALTED, third held in FIFO; start_i → third emitted.
REQ-031 dec_ready_i held low 5 cycles with dec_valid_o high → dec_o stable all 5 cycles, no pop; rst_n asserted in the 3rd cycle → dec_valid_o=0, busy_o=0 immediately.
